// File: rtl/lab_pkg.sv
// Shared types for the min/max register file: the scan sequencer states.
package lab_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/minmax_scan.sv
// Sequential min/max search: walks one entry per cycle and publishes the
// indices of the smallest and largest valid values when the walk ends.
module minmax_scan
  import lab_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             init,
  input  logic             find,
  input  logic             modify,
  input  logic [WIDTH-1:0] ent_data,
  input  logic             ent_valid,
  output logic [AW-1:0]    scan_idx,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  output logic             stale,
  output logic [AW-1:0]    min_idx,
  output logic [AW-1:0]    max_idx
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  scan_state_e      state, state_next;
  logic [AW-1:0]    idx;
  logic             have, have_next;
  logic [WIDTH-1:0] min_val, max_val, min_val_next, max_val_next;
  logic [AW-1:0]    run_min, run_max, run_min_next, run_max_next;
  logic             run_stale, run_stale_next;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    have_next      = have;
    min_val_next   = min_val;
    max_val_next   = max_val;
    run_min_next   = run_min;
    run_max_next   = run_max;
    run_stale_next = run_stale | modify;
    if (state == SCAN && ent_valid) begin
      // Strict compares keep the earlier (lower) index on ties.
      if (!have || ent_data < min_val) begin
        min_val_next = ent_data;
        run_min_next = idx;
      end
      if (!have || ent_data > max_val) begin
        max_val_next = ent_data;
        run_max_next = idx;
      end
      have_next = 1'b1;
    end
    case (state)
      IDLE:    if (find) state_next = SCAN;
      SCAN:    if (idx == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state     <= IDLE;
      idx       <= '0;
      have      <= 1'b0;
      min_val   <= '0;
      max_val   <= '0;
      run_min   <= '0;
      run_max   <= '0;
      run_stale <= 1'b0;
      res_valid <= 1'b0;
      stale     <= 1'b0;
      min_idx   <= '0;
      max_idx   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (find) begin
          idx       <= '0;
          have      <= 1'b0;
          min_val   <= '0;
          max_val   <= '0;
          run_min   <= '0;
          run_max   <= '0;
          run_stale <= 1'b0;
        end
        SCAN: begin
          idx       <= idx + 1'b1;
          have      <= have_next;
          min_val   <= min_val_next;
          max_val   <= max_val_next;
          run_min   <= run_min_next;
          run_max   <= run_max_next;
          run_stale <= run_stale_next;
          if (idx == LAST) begin
            res_valid <= have_next;
            stale     <= run_stale_next;
            min_idx   <= run_min_next;
            max_idx   <= run_max_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign scan_idx = idx;
  assign busy     = (state == SCAN);
  assign done     = (state == DONE);

endmodule

// File: rtl/minmax_regfile.sv
// Small register file with valid bits, an associative lookup returning the
// lowest matching index, occupancy count, and a background min/max scan.
module minmax_regfile
  import lab_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             init,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic             look_en,
  input  logic [WIDTH-1:0] look_data,
  output logic             hit,
  output logic [AW-1:0]    hit_idx,
  input  logic             find,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  output logic             stale,
  output logic [AW-1:0]    min_idx,
  output logic [AW-1:0]    max_idx,
  output logic             any_valid,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             match_hit;
  logic [AW-1:0]    match_idx;
  logic [AW-1:0]    scan_idx;

  // NOTE: the data array is reset along with the valid bits so that every
  // stored word reads as zero after init, not just the valid flags.
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid <= '0;
    end else begin
      // Clear first so a same-address write in the same cycle wins.
      if (clr_en) valid[clr_addr] <= 1'b0;
      if (wr_en) begin
        mem[wr_addr]   <= wr_data;
        valid[wr_addr] <= 1'b1;
      end
    end
  end

  // Descending walk so the lowest matching index is the last one written.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && mem[i] == look_data) begin
        match_hit = 1'b1;
        match_idx = AW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      hit     <= 1'b0;
      hit_idx <= '0;
    end else if (look_en) begin
      hit     <= match_hit;
      hit_idx <= match_idx;
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + (AW + 1)'(valid[i]);
  end

  assign any_valid = |valid;

  minmax_scan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_scan (
    .clk       (clk),
    .init      (init),
    .find      (find),
    .modify    (wr_en | clr_en),
    .ent_data  (mem[scan_idx]),
    .ent_valid (valid[scan_idx]),
    .scan_idx  (scan_idx),
    .busy      (busy),
    .done      (done),
    .res_valid (res_valid),
    .stale     (stale),
    .min_idx   (min_idx),
    .max_idx   (max_idx)
  );

endmodule

// File: doc/minmax_regfile.md
MINMAX_REGFILE -- requirements
Module: minmax_regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of entries, which SHALL be a power of two and at least 2.
REQ-003 The block SHALL use a derived constant AW = clog2(DEPTH) as the entry-index width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 init  in  1  reset, asynchronous, active-low.
REQ-006 wr_en, wr_addr[AW], wr_data[WIDTH]  in  write entry wr_addr with wr_data and set its valid bit.
REQ-007 clr_en, clr_addr[AW]  in  clear the valid bit of entry clr_addr.
REQ-008 look_en, look_data[WIDTH]  in  request a lookup of look_data.
REQ-009 hit  out  1  high when the last lookup matched a valid entry.
REQ-010 hit_idx  out  AW  lowest matching index for the last lookup.
REQ-011 find  in  1  start a min/max scan.
REQ-012 busy  out  1  high while a scan is in progress.
REQ-013 done  out  1  one-cycle pulse at the end of a scan.
REQ-014 res_valid  out  1  high when the last scan saw at least one valid entry.
REQ-015 stale  out  1  high when the last scan overlapped a write or clear.
REQ-016 min_idx, max_idx  out  AW each  result indices of the last scan.
REQ-017 any_valid  out  1  OR of all valid bits.
REQ-018 count  out  AW+1  number of valid entries.

Function
REQ-019 A write or clear SHALL take effect at the clock edge; the entry and valid bit SHALL be visible on the next cycle.
REQ-020 When a write and a clear target the same address in the same cycle, the write SHALL win and the entry SHALL end valid.
REQ-021 Writing an entry that is already valid SHALL overwrite its data and leave it valid.
REQ-022 any_valid and count SHALL reflect the registered valid bits combinationally.
REQ-023 count SHALL equal DEPTH when all entries are valid, with no wrap-around.
REQ-024 When look_en is high, hit and hit_idx SHALL update on the next edge: lowest valid index whose data equals look_data.
REQ-025 When no valid entry matches, hit SHALL be 0 and hit_idx SHALL be 0.
REQ-026 While look_en is low, hit and hit_idx SHALL hold their values.
REQ-027 The scan FSM SHALL have states IDLE, SCAN and DONE.
REQ-028 IDLE -> SCAN when find is high; find SHALL be ignored in SCAN and DONE.
REQ-029 In SCAN the FSM SHALL examine one entry per cycle, index 0 to DEPTH-1, comparing only valid entries as unsigned values against running min and max.
REQ-030 On equal values the lower index SHALL be retained for both min and max.
REQ-031 After entry DEPTH-1 the FSM SHALL go SCAN -> DONE, then DONE -> IDLE unconditionally.
REQ-032 Latency from the find edge to done SHALL be DEPTH+1 cycles; busy SHALL be high for exactly DEPTH cycles (state SCAN).
REQ-033 In DONE, done SHALL be 1 for one cycle, and min_idx, max_idx, res_valid and stale SHALL update together on entry to DONE and hold until the next DONE.
REQ-034 If no entry was valid when examined, res_valid SHALL be 0 and min_idx and max_idx SHALL be 0.
REQ-035 Any write or clear during SCAN SHALL set stale for that result; entry data SHALL be sampled when the entry is examined.

Reset
REQ-036 When init is low, the block SHALL asynchronously clear all valid bits, entry data, hit, hit_idx, min_idx, max_idx, res_valid and stale to 0, and set the FSM to IDLE (busy=0, done=0).
REQ-037 A reset during SCAN SHALL abort the scan with no done pulse.
REQ-038 The first find after reset release SHALL be accepted.

Structure
REQ-039 The state enum (IDLE, SCAN, DONE) SHALL live in shared package lab_pkg.
REQ-040 The min/max scan FSM and its comparators SHALL be in one sub-module, minmax_scan; storage and lookup SHALL remain in the top level.

Verification
REQ-041 Bench SHALL check: reset, then write {3,9,1,9,5} to 0..4, then find -> done at cycle 9, min_idx=2, max_idx=1, res_valid=1, stale=0.
REQ-042 Bench SHALL check: find with all entries invalid -> done after 9 cycles, res_valid=0, min_idx=0, max_idx=0.
REQ-043 Bench SHALL check: write 7 to entries 2 and 5, then look_data=7 -> hit=1, hit_idx=2; clear 2 then lookup -> hit_idx=5; lookup 4 -> hit=0.
REQ-044 Bench SHALL check: simultaneous wr_en and clr_en to address 3 -> entry 3 valid, count increments by 1; fill all 8 entries -> count=8.
REQ-045 Bench SHALL check: write to entry 6 during cycle 3 of a scan -> stale=1 in DONE; reset low mid-scan -> busy=0 immediately and no done pulse.
